argmax_classifier: RTL and testbench
====================================

ARGMAX_CLASSIFIER -- requirements
Module: argmax_classifier

Interface
REQ-001 Parameter NUM_CLASSES, default 10, number of neuron scores per frame (2..16).
REQ-002 Parameter DATA_W, default 32, score width, two's-complement signed.
REQ-003 clock  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-low reset; sampled on rising edge of clock.
REQ-005 clear  in  1  synchronous frame abort; discards partial frame, returns to IDLE.
REQ-006 in_valid  in  1  score present on in_data (one per neuron, class order 0..NUM_CLASSES-1).
REQ-007 in_data  in  DATA_W  neuron ReLU score.
REQ-008 in_ready  out  1  block accepts a score this cycle.
REQ-009 class_out  out  4  index of winning class.
REQ-010 max_out  out  DATA_W  score of winning class.
REQ-011 result_valid  out  1  class_out/max_out hold a completed frame result.
REQ-012 done_pulse  out  1  one-cycle pulse on frame completion.
REQ-013 rd_addr  in  4  score-buffer read index.
REQ-014 rd_data  out  DATA_W  buffered score at rd_addr, one-cycle registered latency.

Function
REQ-015 FSM states IDLE, COLLECT, DONE; a score is accepted when in_valid && in_ready.
REQ-016 in_ready SHALL be 1 in all states except during reset.
REQ-017 IDLE: accepted score -> store as class 0, running max = score, max index = 0, idx = 1, go COLLECT (if NUM_CLASSES>1).
REQ-018 COLLECT: each accepted score stored at buffer[idx]; if score > running max (signed, strict) update max and max index; idx increments.
REQ-019 Ties SHALL resolve to the lowest index (strict greater-than only).
REQ-020 Accepting score idx = NUM_CLASSES-1 SHALL move to DONE; next cycle class_out/max_out updated, result_valid=1, done_pulse=1 for exactly one cycle.
REQ-021 Latency: last score accepted in cycle N -> result_valid and done_pulse high in cycle N+1.
REQ-022 DONE: result_valid, class_out, max_out held stable; accepted score starts new frame as index 0 (as IDLE), result_valid drops the following cycle.
REQ-023 Cycles with in_valid=0 SHALL not change idx, max, or buffer (gaps allowed mid-frame).
REQ-024 clear=1 in any state: next cycle state IDLE, idx=0, result_valid=0, done_pulse=0; a score presented with clear in the same cycle SHALL be discarded; buffer contents retained.
REQ-025 class_out/max_out SHALL update only on frame completion; partial-frame max is internal.
REQ-026 rd_data = buffer[rd_addr] registered; rd_addr >= NUM_CLASSES returns 0.
REQ-027 Write to buffer and read of same address in same cycle returns old value.

Reset
REQ-028 rst=0 at a rising edge: state IDLE, idx=0, class_out=0, max_out=0, result_valid=0, done_pulse=0, rd_data=0, all buffer entries 0.
REQ-029 Reset SHALL take priority over clear and in_valid; reset mid-frame discards the frame.
REQ-030 in_ready=0 during the cycle rst is asserted.

Verification
REQ-031 Scores 5,9,3,9,1,0,2,8,7,4 back-to-back -> cycle after 10th: class_out=1, max_out=9, done_pulse one cycle, result_valid held.
REQ-032 All ten scores 0 -> class_out=0, max_out=0; scores -3..-12 descending (signed) -> class_out=0, max_out=-3.
REQ-033 Max at index 9 (value 100) with random in_valid gaps -> class_out=9 only after 10th accepted score; no early result_valid.
REQ-034 clear after 4 scores, then fresh frame with max 50 at index 6 -> class_out=6, max_out=50; earlier partial max ignored.
REQ-035 rst=0 after 7 scores -> all outputs 0; subsequent full frame classifies correctly from index 0.
REQ-036 After frame, rd_addr 0..9 -> rd_data returns stored scores one cycle later; rd_addr=12 -> 0; new frame in DONE drops result_valid next cycle.

Source files
------------

// File: rtl/argmax_classifier.sv
// Streaming argmax over one frame of NUM_CLASSES signed scores.
// Scores arrive one per accepted beat in class order; the winning index and
// score are published one cycle after the last score, with a one-cycle done
// pulse. Every accepted score is also kept in a small buffer that can be read
// back with one cycle of latency.
//
// Handshake: a score transfers on a rising edge where in_valid && in_ready;
// in_ready is high whenever reset is released, so the producer never stalls.
// A score presented together with clear is dropped.
module argmax_classifier #(
   parameter int NUM_CLASSES = 10,
   parameter int DATA_W      = 32
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              clear,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic [3:0]        class_out,
   output logic [DATA_W-1:0] max_out,
   output logic              result_valid,
   output logic              done_pulse,
   input  logic [3:0]        rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic [1:0]        state_o
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);
   localparam logic [4:0] NUM_C    = 5'(NUM_CLASSES);

   state_t            state_q, state_d;
   logic [3:0]        idx_q, idx_d;
   logic [DATA_W-1:0] run_max_q, run_max_d;
   logic [3:0]        run_idx_q, run_idx_d;
   logic [3:0]        class_q, class_d;
   logic [DATA_W-1:0] max_q, max_d;
   logic              valid_q, valid_d;
   logic              done_q, done_d;
   logic [DATA_W-1:0] rd_data_q;
   logic [DATA_W-1:0] buffer_q [16];

   logic              accept;
   logic              greater;
   logic [3:0]        wr_addr;

   assign in_ready = rst;
   assign accept   = in_valid && in_ready && !clear;
   assign greater  = $signed(in_data) > $signed(run_max_q);
   assign wr_addr  = (state_q == S_COLLECT) ? idx_q : 4'd0;

   // Next-state and datapath update; a new frame starts from IDLE or DONE.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      run_max_d = run_max_q;
      run_idx_d = run_idx_q;
      class_d   = class_q;
      max_d     = max_q;
      valid_d   = valid_q;
      done_d    = 1'b0;
      if (clear) begin
         state_d = S_IDLE;
         idx_d   = 4'd0;
         valid_d = 1'b0;
      end else if (accept) begin
         unique case (state_q)
            S_COLLECT: begin
               if (greater) begin
                  run_max_d = in_data;
                  run_idx_d = idx_q;
               end
               if (idx_q == LAST_IDX) begin
                  state_d = S_DONE;
                  idx_d   = 4'd0;
                  class_d = greater ? idx_q : run_idx_q;
                  max_d   = greater ? in_data : run_max_q;
                  valid_d = 1'b1;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
            default: begin
               state_d   = S_COLLECT;
               idx_d     = 4'd1;
               run_max_d = in_data;
               run_idx_d = 4'd0;
               valid_d   = 1'b0;
            end
         endcase
      end
   end

   // State and result registers.
   always_ff @(posedge clock) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         idx_q     <= 4'd0;
         run_max_q <= '0;
         run_idx_q <= 4'd0;
         class_q   <= 4'd0;
         max_q     <= '0;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         run_max_q <= run_max_d;
         run_idx_q <= run_idx_d;
         class_q   <= class_d;
         max_q     <= max_d;
         valid_q   <= valid_d;
         done_q    <= done_d;
      end
   end

   // Score buffer; a read in the same cycle as a write sees the old value.
   always_ff @(posedge clock) begin
      if (!rst) begin
         for (int i = 0; i < 16; i++) buffer_q[i] <= '0;
         rd_data_q <= '0;
      end else begin
         if (accept) buffer_q[wr_addr] <= in_data;
         rd_data_q <= ({1'b0, rd_addr} < NUM_C) ? buffer_q[rd_addr] : '0;
      end
   end

   assign class_out    = class_q;
   assign max_out      = max_q;
   assign result_valid = valid_q;
   assign done_pulse   = done_q;
   assign rd_data      = rd_data_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed bench for argmax_classifier: classification, ties, gaps, clear,
// mid-frame reset, buffer readback and back-to-back frames.
module tb_argmax_classifier;

   logic        clock = 1'b0;
   logic        rst;
   logic        clear;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic [3:0]  class_out;
   logic [31:0] max_out;
   logic        result_valid;
   logic        done_pulse;
   logic [3:0]  rd_addr;
   logic [31:0] rd_data;
   logic [1:0]  state_o;

   int          tests_run = 0;
   int          tests_failed = 0;
   logic [31:0] exp_buf [16];
   logic [31:0] frame_v [10];

   argmax_classifier #(.NUM_CLASSES(10), .DATA_W(32)) dut (
      .clock(clock), .rst(rst), .clear(clear), .in_valid(in_valid),
      .in_data(in_data), .in_ready(in_ready), .class_out(class_out),
      .max_out(max_out), .result_valid(result_valid), .done_pulse(done_pulse),
      .rd_addr(rd_addr), .rd_data(rd_data), .state_o(state_o)
   );

   // Clock generation.
   always #5 clock = ~clock;

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic send_score(input logic [31:0] d);
      in_valid = 1'b1;
      in_data  = d;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input bit gaps);
      for (int i = 0; i < 10; i++) begin
         if (gaps) idle($urandom_range(0, 2));
         exp_buf[i] = frame_v[i];
         send_score(frame_v[i]);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; clear = 1'b0; in_valid = 1'b1; in_data = 32'd77; rd_addr = 4'd0;
      #1;
      tests_run++;
      if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
      @(posedge clock); #1;
      in_valid = 1'b0;
      tests_run++;
      if (class_out !== 4'd0 || max_out !== 32'd0 || result_valid !== 1'b0 || done_pulse !== 1'b0 || rd_data !== 32'd0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got cls=%0d max=%0d rv=%b dp=%b rd=%0d expected all 0", class_out, max_out, result_valid, done_pulse, rd_data);
      end
      rst = 1'b1;
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL ready_after_reset: got %b expected 1", in_ready); end
      for (int i = 0; i < 16; i++) exp_buf[i] = 32'd0;
   endtask

   task automatic test_basic();
      frame_v = '{5, 9, 3, 9, 1, 0, 2, 8, 7, 4};
      send_frame(1'b0);
      tests_run++;
      if (class_out !== 4'd1 || max_out !== 32'd9 || done_pulse !== 1'b1 || result_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL basic_result: got cls=%0d max=%0d dp=%b rv=%b expected cls=1 max=9 dp=1 rv=1", class_out, max_out, done_pulse, result_valid);
      end
      idle(2);
      tests_run++;
      if (done_pulse !== 1'b0 || result_valid !== 1'b1 || class_out !== 4'd1 || max_out !== 32'd9) begin
         tests_failed++;
         $display("FAIL basic_hold: got dp=%b rv=%b cls=%0d max=%0d expected dp=0 rv=1 cls=1 max=9", done_pulse, result_valid, class_out, max_out);
      end
   endtask

   task automatic test_zeros_negative();
      frame_v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      send_frame(1'b0);
      tests_run++;
      if (class_out !== 4'd0 || max_out !== 32'd0 || done_pulse !== 1'b1) begin
         tests_failed++;
         $display("FAIL zeros_result: got cls=%0d max=%0d dp=%b expected cls=0 max=0 dp=1", class_out, max_out, done_pulse);
      end
      frame_v = '{-3, -4, -5, -6, -7, -8, -9, -10, -11, -12};
      send_frame(1'b0);
      tests_run++;
      if (class_out !== 4'd0 || $signed(max_out) !== -32'sd3 || result_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL negative_result: got cls=%0d max=%0d rv=%b expected cls=0 max=-3 rv=1", class_out, $signed(max_out), result_valid);
      end
   endtask

   task automatic test_gaps();
      frame_v = '{11, 22, 99, 44, 55, 66, 77, 88, 99, 100};
      for (int i = 0; i < 10; i++) begin
         idle($urandom_range(0, 3));
         exp_buf[i] = frame_v[i];
         send_score(frame_v[i]);
         if (i < 9) begin
            tests_run++;
            if (result_valid !== 1'b0 || done_pulse !== 1'b0 || class_out !== 4'd0) begin
               tests_failed++;
               $display("FAIL gaps_early_%0d: got rv=%b dp=%b cls=%0d expected rv=0 dp=0 cls=0", i, result_valid, done_pulse, class_out);
            end
         end
      end
      tests_run++;
      if (class_out !== 4'd9 || max_out !== 32'd100 || done_pulse !== 1'b1 || result_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL gaps_result: got cls=%0d max=%0d dp=%b rv=%b expected cls=9 max=100 dp=1 rv=1", class_out, max_out, done_pulse, result_valid);
      end
   endtask

   task automatic test_clear();
      frame_v = '{200, 1, 2, 3, 0, 0, 0, 0, 0, 0};
      for (int i = 0; i < 4; i++) begin
         exp_buf[i] = frame_v[i];
         send_score(frame_v[i]);
      end
      clear = 1'b1; in_valid = 1'b1; in_data = 32'd999;
      @(posedge clock); #1;
      clear = 1'b0; in_valid = 1'b0;
      tests_run++;
      if (result_valid !== 1'b0 || done_pulse !== 1'b0 || state_o !== 2'd0) begin
         tests_failed++;
         $display("FAIL clear_state: got rv=%b dp=%b st=%0d expected rv=0 dp=0 st=0", result_valid, done_pulse, state_o);
      end
      frame_v = '{10, 20, 30, 40, 1, 2, 50, 3, 4, 5};
      send_frame(1'b0);
      tests_run++;
      if (class_out !== 4'd6 || max_out !== 32'd50 || done_pulse !== 1'b1) begin
         tests_failed++;
         $display("FAIL clear_refill: got cls=%0d max=%0d dp=%b expected cls=6 max=50 dp=1", class_out, max_out, done_pulse);
      end
   endtask

   task automatic test_reset_mid();
      frame_v = '{1, 2, 500, 4, 5, 6, 7, 0, 0, 0};
      for (int i = 0; i < 7; i++) send_score(frame_v[i]);
      rst = 1'b0; clear = 1'b1; in_valid = 1'b1; in_data = 32'd600; rd_addr = 4'd2;
      #1;
      tests_run++;
      if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL midreset_ready: got %b expected 0", in_ready); end
      @(posedge clock); #1;
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0;
      tests_run++;
      if (class_out !== 4'd0 || max_out !== 32'd0 || result_valid !== 1'b0 || done_pulse !== 1'b0 || rd_data !== 32'd0) begin
         tests_failed++;
         $display("FAIL midreset_outputs: got cls=%0d max=%0d rv=%b dp=%b rd=%0d expected all 0", class_out, max_out, result_valid, done_pulse, rd_data);
      end
      for (int i = 0; i < 16; i++) exp_buf[i] = 32'd0;
      idle(1);
      tests_run++;
      if (rd_data !== 32'd0) begin tests_failed++; $display("FAIL midreset_buffer: got %0d expected 0", rd_data); end
      frame_v = '{1, 2, 3, 4, 5, 6, 7, 8, 77, 9};
      send_frame(1'b0);
      tests_run++;
      if (class_out !== 4'd8 || max_out !== 32'd77 || done_pulse !== 1'b1) begin
         tests_failed++;
         $display("FAIL midreset_refill: got cls=%0d max=%0d dp=%b expected cls=8 max=77 dp=1", class_out, max_out, done_pulse);
      end
   endtask

   task automatic test_readback();
      for (int i = 0; i < 10; i++) begin
         rd_addr = 4'(i);
         idle(1);
         tests_run++;
         if (rd_data !== exp_buf[i]) begin
            tests_failed++;
            $display("FAIL readback_%0d: got %0d expected %0d", i, rd_data, exp_buf[i]);
         end
      end
      rd_addr = 4'd12;
      idle(1);
      tests_run++;
      if (rd_data !== 32'd0) begin tests_failed++; $display("FAIL readback_oob: got %0d expected 0", rd_data); end
      rd_addr = 4'd0;
      send_score(32'd123);
      tests_run++;
      if (rd_data !== exp_buf[0] || result_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL readback_same_cycle: got rd=%0d rv=%b expected rd=%0d rv=0", rd_data, result_valid, exp_buf[0]);
      end
      exp_buf[0] = 32'd123;
      idle(1);
      tests_run++;
      if (rd_data !== 32'd123) begin tests_failed++; $display("FAIL readback_new: got %0d expected 123", rd_data); end
      clear = 1'b1;
      idle(1);
      clear = 1'b0;
   endtask

   task automatic test_back_to_back();
      frame_v = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
      send_frame(1'b0);
      tests_run++;
      if (class_out !== 4'd5 || max_out !== 32'd9 || done_pulse !== 1'b1) begin
         tests_failed++;
         $display("FAIL b2b_first: got cls=%0d max=%0d dp=%b expected cls=5 max=9 dp=1", class_out, max_out, done_pulse);
      end
      frame_v = '{7, 3, 7, 7, 2, 7, 1, 0, 7, 6};
      exp_buf[0] = frame_v[0];
      send_score(frame_v[0]);
      tests_run++;
      if (done_pulse !== 1'b0 || result_valid !== 1'b0 || class_out !== 4'd5) begin
         tests_failed++;
         $display("FAIL b2b_restart: got dp=%b rv=%b cls=%0d expected dp=0 rv=0 cls=5", done_pulse, result_valid, class_out);
      end
      for (int i = 1; i < 10; i++) begin
         exp_buf[i] = frame_v[i];
         send_score(frame_v[i]);
      end
      tests_run++;
      if (class_out !== 4'd0 || max_out !== 32'd7 || done_pulse !== 1'b1 || result_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL b2b_tie: got cls=%0d max=%0d dp=%b rv=%b expected cls=0 max=7 dp=1 rv=1", class_out, max_out, done_pulse, result_valid);
      end
   endtask

   // Test sequence and summary.
   initial begin
      test_reset();
      test_basic();
      test_zeros_negative();
      test_gaps();
      test_clear();
      test_reset_mid();
      test_readback();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
